cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among the four functional-unit result sources: alu, mul, br and mem.
- Each source hands its result in through a valid/ready handshake into a one-entry holding slot.
- Every cycle the arbiter grants at most one occupied slot onto the CDB, which the reservation stations and the ROB snoop.
- Backpressure on `res_ready` lets an execution unit and its reservation station stall when the CDB is contended.

---
 rtl/rv32i_types.sv | 34 +++
 rtl/cdb_rr_arbiter.sv | 59 +++++
 rtl/cdb_arbiter.sv | 151 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the result-broadcast path: source ids, CDB payload struct, ROB age helper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable; consumers define their own flow control.
package rv32i_types;

    localparam int CDB_NUM_SRC       = 4;
    localparam int CDB_ROB_IDX_WIDTH = 5;
    localparam int CDB_DATA_WIDTH    = 32;
    localparam int REG_ADDR_WIDTH    = 5;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_BR  = 2'd2,
        SRC_MEM = 2'd3
    } cdb_src_t;

    typedef struct packed {
        logic                         valid;
        logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
        logic [REG_ADDR_WIDTH-1:0]    rd_addr;
        logic                         regf_we;
        logic [CDB_DATA_WIDTH-1:0]    data;
    } cdb_result_t;

    // Distance of a ROB entry from the head; smaller means older. Wraps modulo the index space.
    function automatic logic [CDB_ROB_IDX_WIDTH-1:0] rob_age(
        input logic [CDB_ROB_IDX_WIDTH-1:0] idx,
        input logic [CDB_ROB_IDX_WIDTH-1:0] head
    );
        return idx - head;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant, scan starts at an internal pointer.
// Latency: grant is combinational from req; pointer moves to grant+1 at the next edge.
// Backpressure: adv_en=0 freezes the pointer (grant still shown but treated as not taken).
module cdb_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv_en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Scan upward from ptr_q modulo N; the first requester wins.
    always_comb begin
        int cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_vld && req[PW'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner when the grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld && adv_en) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: four one-entry result slots, one slot broadcast per cycle (round-robin, or oldest-first with CDB_AGE_PRIORITY_EN).
// Latency: accept at cycle T, broadcast at T+1 at the earliest; no same-cycle bypass.
// Backpressure: res_ready[i] drops while slot i is full and not granted, and during flush.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_SRC       = CDB_NUM_SRC,
    parameter int ROB_IDX_WIDTH = CDB_ROB_IDX_WIDTH,
    parameter int DATA_WIDTH    = CDB_DATA_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [ROB_IDX_WIDTH-1:0]                rob_head,
    input  logic [NUM_SRC-1:0]                      res_valid,
    output logic [NUM_SRC-1:0]                      res_ready,
    input  logic [NUM_SRC-1:0][ROB_IDX_WIDTH-1:0]   res_rob_idx,
    input  logic [NUM_SRC-1:0][4:0]                 res_rd_addr,
    input  logic [NUM_SRC-1:0]                      res_regf_we,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]      res_data,
    output logic                                    cdb_valid,
    output logic [1:0]                              cdb_src,
    output logic [ROB_IDX_WIDTH-1:0]                cdb_rob_idx,
    output logic [4:0]                              cdb_rd_addr,
    output logic                                    cdb_regf_we,
    output logic [DATA_WIDTH-1:0]                   cdb_data
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Slot payload widths come from rv32i_types; the parameters above only mirror them.
    cdb_result_t        slot_q [NUM_SRC];
    cdb_result_t        slot_d [NUM_SRC];
    logic [NUM_SRC-1:0] slot_vld;
    logic [NUM_SRC-1:0] gnt_raw;
    logic [NUM_SRC-1:0] gnt;
    logic [SW-1:0]      gnt_idx;
    logic               gnt_vld;
    cdb_src_t           src_sel;

    // Occupancy vector feeding the grant logic.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_vld[i] = slot_q[i].valid;
        end
    end

`ifdef CDB_AGE_PRIORITY_EN
    // Oldest occupied slot (smallest distance from rob_head) wins; ROB indices are unique so no ties.
    always_comb begin
        logic [ROB_IDX_WIDTH-1:0] best_age;
        logic [ROB_IDX_WIDTH-1:0] age;
        gnt_raw  = '0;
        gnt_idx  = '0;
        gnt_vld  = 1'b0;
        best_age = '1;
        age      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            age = rob_age(slot_q[i].rob_idx, rob_head);
            if (slot_vld[i] && (!gnt_vld || (age < best_age))) begin
                gnt_vld  = 1'b1;
                gnt_idx  = SW'(i);
                best_age = age;
            end
        end
        if (gnt_vld) begin
            gnt_raw[gnt_idx] = 1'b1;
        end
    end
`else
    // Round-robin; the pointer must not move in a flush cycle since nothing is broadcast.
    cdb_rr_arbiter #(
        .N  (NUM_SRC),
        .PW (SW)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (slot_vld),
        .adv_en  (!flush),
        .gnt     (gnt_raw),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    logic unused_rob_head;
    assign unused_rob_head = ^rob_head;
`endif

    // A grant only takes effect (drains a slot) outside a flush.
    always_comb begin
        gnt = flush ? '0 : gnt_raw;
    end

    // A slot can accept when empty or being drained this cycle; never during flush.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            res_ready[i] = !flush && (!slot_vld[i] || gnt[i]);
        end
    end

    // Slot next state: drain on grant, refill on accept, flush clears everything last.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_d[i] = slot_q[i];
            if (gnt[i]) begin
                slot_d[i].valid = 1'b0;
            end
            if (res_valid[i] && res_ready[i]) begin
                slot_d[i].valid   = 1'b1;
                slot_d[i].rob_idx = res_rob_idx[i];
                slot_d[i].rd_addr = res_rd_addr[i];
                slot_d[i].regf_we = res_regf_we[i];
                slot_d[i].data    = res_data[i];
            end
            if (flush) begin
                slot_d[i].valid = 1'b0;
            end
        end
    end

    // Slot registers, synchronous active-low reset clears valid and payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    // Broadcast mux from the granted slot; all fields forced to zero when idle or flushing.
    always_comb begin
        cdb_valid   = 1'b0;
        src_sel     = SRC_ALU;
        cdb_rob_idx = '0;
        cdb_rd_addr = '0;
        cdb_regf_we = 1'b0;
        cdb_data    = '0;
        if (gnt_vld && !flush) begin
            cdb_valid   = 1'b1;
            src_sel     = cdb_src_t'(gnt_idx);
            cdb_rob_idx = slot_q[gnt_idx].rob_idx;
            cdb_rd_addr = slot_q[gnt_idx].rd_addr;
            cdb_regf_we = slot_q[gnt_idx].regf_we;
            cdb_data    = slot_q[gnt_idx].data;
        end
        cdb_src = src_sel;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed stimulus, expected broadcasts queued in a scoreboard, monitor checks every cycle.
// Latency: scoreboard relies on ordering only, so it tolerates the one-cycle accept-to-broadcast delay.
// Backpressure: sources hold payload while res_ready is low; CDB_AGE_PRIORITY_EN selects the age-order scenarios.
module tb_cdb_arbiter;

    typedef struct packed {
        logic [1:0]  src;
        logic [4:0]  rob;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [4:0]       rob_head;
    logic [3:0]       res_valid;
    logic [3:0]       res_ready;
    logic [3:0][4:0]  res_rob_idx;
    logic [3:0][4:0]  res_rd_addr;
    logic [3:0]       res_regf_we;
    logic [3:0][31:0] res_data;
    logic             cdb_valid;
    logic [1:0]       cdb_src;
    logic [4:0]       cdb_rob_idx;
    logic [4:0]       cdb_rd_addr;
    logic             cdb_regf_we;
    logic [31:0]      cdb_data;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rob_head    (rob_head),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_rob_idx (res_rob_idx),
        .res_rd_addr (res_rd_addr),
        .res_regf_we (res_regf_we),
        .res_data    (res_data),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_rd_addr (cdb_rd_addr),
        .cdb_regf_we (cdb_regf_we),
        .cdb_data    (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload tag: every field is derived from (source, rob) so mixups are visible.
    function automatic exp_t mk(input int s, input int r);
        exp_t e;
        logic [31:0] sv;
        logic [31:0] rv;
        sv     = 32'(s);
        rv     = 32'(r);
        e.src  = sv[1:0];
        e.rob  = rv[4:0];
        e.rd   = 5'(r + 3 * s);
        e.we   = rv[0] ^ sv[0];
        e.data = 32'hC0DE_0000 | (sv << 8) | rv;
        return e;
    endfunction

    task automatic drive(input int s, input int r);
        exp_t e;
        e = mk(s, r);
        res_rob_idx[s] = e.rob;
        res_rd_addr[s] = e.rd;
        res_regf_we[s] = e.we;
        res_data[s]    = e.data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare on every broadcast; idle cycles must show all-zero fields.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cdb_valid === 1'b1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_bcast: got src %0d rob %0d expected no broadcast at %0t",
                                 cdb_src, cdb_rob_idx, $time);
                    end else begin
                        e = sb.pop_front();
                        if ({cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data} !== e) begin
                            n_bad++;
                            $display("FAIL bcast: got src %0d rob %0d rd %0d we %0d data %0h expected src %0d rob %0d rd %0d we %0d data %0h at %0t",
                                     cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data,
                                     e.src, e.rob, e.rd, e.we, e.data, $time);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (cdb_valid !== 1'b0 ||
                        {cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data} !== 45'd0) begin
                        n_bad++;
                        $display("FAIL idle_fields: got valid %b data %0h rob %0d expected all zero at %0t",
                                 cdb_valid, cdb_data, cdb_rob_idx, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ca;
        int cm;
        int stall_a;
        int stall_m;
        int max_stall;
        int guard;
        logic acc_a;
        logic acc_m;

        rst       = 1'b0;
        flush     = 1'b0;
        rob_head  = '0;
        res_valid = 4'b1111;
        for (int i = 0; i < 4; i++) drive(i, 7);

        // Reset held two edges with all sources valid: nothing captured or shown.
        step();
        step();
        #2;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_res_ready", 32'(res_ready), 32'hF);
        chk("rst_cdb_data", cdb_data, 32'd0);
        mon_en = 1'b1;

        // Release reset with all four presenting rob 3..6: pointer at 0 so alu first.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 3 + i);
        for (int i = 0; i < 4; i++) sb.push_back(mk(i, 3 + i));
        chk("cont_ready_fill", 32'(res_ready), 32'hF);
        step();
        res_valid = 4'b0000;
        #2;
        chk("cont_ready_0", 32'(res_ready), 32'h1);
        step();
        #2;
        chk("cont_ready_1", 32'(res_ready), 32'h3);
        step();
        #2;
        chk("cont_ready_2", 32'(res_ready), 32'h7);
        step();
        #2;
        chk("cont_ready_3", 32'(res_ready), 32'hF);

        // Streaming alu rob 0..9, one per cycle, ready never drops.
        for (int k = 0; k < 10; k++) begin
            step();
            drive(0, k);
            res_valid = 4'b0001;
            sb.push_back(mk(0, k));
            #2;
            chk("stream_ready", 32'(res_ready[0]), 32'd1);
        end
        step();
        res_valid = 4'b0000;
        step();

`ifdef CDB_AGE_PRIORITY_EN
        // Head at 30: mem rob 31 (age 1) beats alu rob 2 (age 4).
        rob_head  = 5'd30;
        drive(0, 2);
        drive(3, 31);
        res_valid = 4'b1001;
        sb.push_back(mk(3, 31));
        sb.push_back(mk(0, 2));
        step();
        res_valid = 4'b0000;
        step();
        step();
        step();
        rob_head = 5'd0;
`else
        // Fairness: alu rob 8.., mul rob 16.. continuously valid; pointer sits at 1 after streaming,
        // so mul goes first and the two alternate.
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(1, 16 + k));
            sb.push_back(mk(0, 8 + k));
        end
        ca        = 0;
        cm        = 0;
        stall_a   = 0;
        stall_m   = 0;
        max_stall = 0;
        guard     = 0;
        while ((ca < 4 || cm < 4) && guard < 40) begin
            res_valid[0] = (ca < 4);
            res_valid[1] = (cm < 4);
            drive(0, 8 + ca);
            drive(1, 16 + cm);
            #2;
            acc_a = res_valid[0] && res_ready[0];
            acc_m = res_valid[1] && res_ready[1];
            stall_a = (res_valid[0] && !res_ready[0]) ? stall_a + 1 : 0;
            stall_m = (res_valid[1] && !res_ready[1]) ? stall_m + 1 : 0;
            if (stall_a > max_stall) max_stall = stall_a;
            if (stall_m > max_stall) max_stall = stall_m;
            step();
            if (acc_a) ca++;
            if (acc_m) cm++;
            guard++;
        end
        res_valid = 4'b0000;
        chk("fair_accepts", 32'(ca + cm), 32'd8);
        chk("fair_max_wait", 32'(max_stall), 32'd1);
        for (int k = 0; k < 4; k++) step();
`endif

        // Fill all four slots, then flush while every source keeps offering new results.
        for (int i = 0; i < 4; i++) drive(i, 20 + i);
        res_valid = 4'b1111;
        step();
        flush = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 28 + i);
        #2;
        chk("flush_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("flush_ready", 32'(res_ready), 32'h0);
        step();
        flush     = 1'b0;
        res_valid = 4'b0000;
        #2;
        chk("post_flush_ready", 32'(res_ready), 32'hF);
        chk("post_flush_valid", 32'(cdb_valid), 32'd0);
        step();
        step();

        // Refill after flush: pointer must still be where it was before the flush.
        for (int i = 0; i < 4; i++) drive(i, 24 + i);
        res_valid = 4'b1111;
`ifdef CDB_AGE_PRIORITY_EN
        for (int i = 0; i < 4; i++) sb.push_back(mk(i, 24 + i));
`else
        sb.push_back(mk(1, 25));
        sb.push_back(mk(2, 26));
        sb.push_back(mk(3, 27));
        sb.push_back(mk(0, 24));
`endif
        step();
        res_valid = 4'b0000;
        for (int k = 0; k < 6; k++) step();

        mon_en = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
